// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared state encoding, buffer depth and width defaults for the FIFO read drain
package fifo_rd_pkg;

  localparam int DATA_SIZE_DEF = 8;
  localparam int BUF_DEPTH     = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_ACTIVE   = 2'd1;
  localparam state_t ST_STOPPING = 2'd2;

  // Circular pointer step over the BUF_DEPTH buffer slots.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// rtl/rd_skid_buf.sv - three-entry in-order buffer between FIFO read data and the output port
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] push_data,
  input  logic                 pop,
  output logic [1:0]           occ,
  output logic [DATA_SIZE-1:0] head_data
);

  logic [DATA_SIZE-1:0] mem_q [BUF_DEPTH];
  logic [DATA_SIZE-1:0] mem_d [BUF_DEPTH];
  logic [1:0]           rd_ptr_q, rd_ptr_d;
  logic [1:0]           wr_ptr_q, wr_ptr_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 do_push, do_pop;

  // A push into a full buffer is only accepted when the head leaves that same cycle.
  assign do_pop  = pop && (cnt_q != 2'd0);
  assign do_push = push && ((cnt_q != 2'(BUF_DEPTH)) || do_pop);

  always_comb begin
    for (int i = 0; i < BUF_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      cnt_q    <= 2'd0;
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign occ       = cnt_q;
  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_drain.sv
// rtl/fifo_rd_drain.sv - drains a FIFO with one-cycle read latency into a ready/valid output stream
module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int CNT_W     = 16
) (
  input  logic                 r_clk,
  input  logic                 r_rst_n,
  input  logic                 empty,
  input  logic [DATA_SIZE-1:0] r_data,
  output logic                 r_en,
  input  logic                 enable,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 busy,
  output logic [CNT_W-1:0]     word_cnt
);

  state_t           state_q, state_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]       occ;
  logic             pop;

  rd_skid_buf #(
    .DATA_SIZE(DATA_SIZE)
  ) u_buf (
    .clk      (r_clk),
    .rst_n    (r_rst_n),
    .push     (inflight_q),
    .push_data(r_data),
    .pop      (pop),
    .occ      (occ),
    .head_data(out_data)
  );

  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid && out_ready;

  // Reads stop the moment enable drops, and never outrun the free buffer slots.
  assign r_en = (state_q == ST_ACTIVE) && enable && !empty &&
                (({1'b0, occ} + {2'b00, inflight_q}) <= 3'd2);

  always_comb begin
    state_d    = state_q;
    inflight_d = r_en;
    word_cnt_d = pop ? word_cnt_q + CNT_W'(1) : word_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!enable) state_d = inflight_q ? ST_STOPPING : ST_IDLE;
      end
      ST_STOPPING: begin
        if (!inflight_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign busy     = (state_q != ST_IDLE) || inflight_q || (occ != 2'd0);
  assign word_cnt = word_cnt_q;

endmodule

// File: doc/fifo_rd_drain.md
FIFO_RD_DRAIN -- requirements
Module: fifo_rd_drain

Interface
REQ-001 Parameter DATA_SIZE, default 8, SHALL set the width of read data and output data in bits.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the delivered-word counter.
REQ-003 r_clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 r_rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 empty  input  1  SHALL carry the FIFO empty flag, already in the r_clk domain.
REQ-006 r_data  input  DATA_SIZE  SHALL carry FIFO read data, valid the cycle after a sampled read.
REQ-007 r_en  output  1  SHALL be the FIFO read enable.
REQ-008 enable  input  1  SHALL be the run request; high means drain the FIFO.
REQ-009 out_valid  output  1  SHALL flag valid out_data.
REQ-010 out_ready  input  1  SHALL be the downstream accept; transfer when out_valid and out_ready are both high.
REQ-011 out_data  output  DATA_SIZE  SHALL be the head word of the internal buffer.
REQ-012 busy  output  1  SHALL be high when state is not IDLE, a read is in flight, or the buffer is non-empty.
REQ-013 word_cnt  output  CNT_W  SHALL count completed output transfers.

Function
REQ-014 FIFO read timing: r_en sampled high with empty low at edge E; r_data valid after E; the block SHALL capture it at edge E+1 (in-flight flag set at E, cleared at E+1).
REQ-015 Buffer: 3 entries, in-order; occupancy 0..3.
REQ-016 r_en SHALL be combinational: high only when state is ACTIVE, empty is low, and occupancy plus in-flight is at most 2.
REQ-017 r_en SHALL never be high while empty is high.
REQ-018 Latency: r_en high in cycle k SHALL give out_valid high in cycle k+2 when the buffer was empty.
REQ-019 Throughput: with out_ready held high and the FIFO non-empty, the block SHALL deliver one word per cycle after the first word.
REQ-020 out_valid SHALL equal occupancy not equal to 0; out_data and out_valid SHALL hold stable while out_valid is high and out_ready is low.
REQ-021 A capture and a pop in the same cycle SHALL leave occupancy unchanged and preserve order.
REQ-022 FSM states SHALL be IDLE, ACTIVE and STOPPING.
REQ-023 IDLE SHALL go to ACTIVE when enable is high.
REQ-024 ACTIVE SHALL go to IDLE when enable is low and no read is in flight, and to STOPPING when enable is low and a read is in flight.
REQ-025 STOPPING SHALL go to IDLE on the cycle the in-flight word is captured, ignoring enable.
REQ-026 The buffer SHALL keep draining to the output in every state; no word is dropped when enable falls.
REQ-027 word_cnt SHALL increment by 1 per transfer and wrap from 2^CNT_W-1 to 0.

Reset
REQ-028 While r_rst_n is low: r_en 0, out_valid 0, out_data 0, busy 0, word_cnt 0, FSM in IDLE, occupancy 0, in-flight 0.
REQ-029 Reset mid-operation SHALL discard buffered and in-flight words with no further r_en until after release.
REQ-030 After release, the first r_en SHALL NOT occur before the first edge with enable high.

Structure
REQ-031 Package fifo_rd_pkg SHALL hold the FSM state enumeration, the buffer depth constant (3), and the DATA_SIZE default.
REQ-032 The 3-entry in-order buffer SHALL be the sub-module rd_skid_buf (push, pop, occupancy, head data); the FSM, in-flight flag, r_en logic and counter stay in fifo_rd_drain.

Verification
REQ-033 FIFO model preloaded A1,B2,C3,D4; enable=1; out_ready=1 -> out_data A1,B2,C3,D4 on 4 consecutive cycles, first at r_en cycle+2; word_cnt=4; busy falls after D4.
REQ-034 Same preload; out_ready=0 for 10 cycles, then 1 -> exactly 3 reads issued while stalled; out_data holds A1; then A1..D4 in order with no loss.
REQ-035 enable dropped the cycle after the first r_en -> STOPPING; A1 captured and delivered; no second r_en; FSM IDLE; B2 stays in FIFO.
REQ-036 empty toggling every cycle with random out_ready -> r_en never high with empty high; output order matches write order across 100 words.
REQ-037 r_rst_n pulsed low with 2 words buffered -> out_valid 0 immediately; word_cnt 0; no r_en until enable is seen high after release.
REQ-038 word_cnt preset via 2^CNT_W-1 transfers (CNT_W=4: 15), one more transfer -> word_cnt=0.
